mips_regfile_mp: RTL and testbench
==================================

Name: mips_regfile_mp

Overview:
Parametrised, multi-read-port MIPS general-purpose register file. It replaces the fixed 32x32, two-read-port register file in the single-cycle MIPS core.
- Adds a sequenced post-reset clear with a busy flag.
- Adds a dedicated debug/preload write port, so benches load registers through ports instead of poking the array hierarchically.
- Sits between the decode stage (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W]
we  in  1  functional (writeback) write enable
wr_addr  in  ADDR_W  functional write address
wr_data  in  DATA_W  functional write data
dbg_we  in  1  debug/preload write enable
dbg_addr  in  ADDR_W  debug write address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  registered; 1 the cycle after a debug write is accepted
busy  out  1  registered; 1 while clear sequence runs

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high: sampled only on the rising edge of clk.
- States: CLEAR and READY.
- Edge with rst=1: state<=CLEAR, clr_ptr<=1, busy<=1, dbg_ack<=0. Array contents are not touched on that edge.
- CLEAR, each cycle:
  - reg[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1 is written: state<=READY, busy<=0.
  - Clear therefore takes DEPTH-1 cycles after rst deasserts (31 for defaults).
  - rst reasserted mid-clear restarts at clr_ptr=1.
- While busy=1:
  - All rd_data ports read 0.
  - we and dbg_we are ignored; dbg_ack stays 0.
- READY, reads:
  - Combinational, zero latency: rd_data[i] = reg[rd_addr[i]].
  - Address 0 always reads 0.
- READY, writes (rising edge):
  - we=1 and wr_addr!=0: reg[wr_addr]<=wr_data.
  - dbg_we=1 and we=0 and dbg_addr!=0: reg[dbg_addr]<=dbg_wdata; dbg_ack<=1 next cycle.
  - Both enables asserted: functional write wins; debug write dropped; dbg_ack<=0. The debug source must retry.
  - Writes to address 0 are discarded. A debug write to address 0 still acks (dbg_ack=1).
- Read of an address being written in the same cycle returns the OLD value unless the optional feature is enabled.
- Register 0 is never physically written; it may be implemented as a constant.
- Reset values: busy=1, dbg_ack=0, rd_data=0 (due to busy). Array storage has no reset beyond the clear sequence.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-first forwarding on every read port. When we=1, wr_addr!=0, wr_addr==rd_addr[i] and busy=0, then rd_data[i]=wr_data in the same cycle.
  - The debug port is not forwarded.
  - Address 0 still reads 0.
- Undefined: no forwarding; same-cycle read returns the pre-write value.

Test Plan:
1. Assert rst for 2 cycles, then release -> busy=1 for exactly 31 cycles, then 0. Every rd_data reads 0 throughout, and every register reads 0 afterwards.
2. Debug-preload r1=32'h00000001 and r2=32'h00000000 -> dbg_ack pulses 1 cycle after each. rd_addr={5'd2,5'd1} yields rd_data={32'h0,32'h1}.
3. Issue we=1, wr_addr=2, wr_data=32'h00000001 together with dbg_we=1, dbg_addr=3, dbg_wdata=32'hDEADBEEF -> r2=1, r3 remains 0, dbg_ack=0.
4. Write we=1, wr_addr=0, wr_data=32'hFFFFFFFF; dbg write to address 0 -> r0 reads 0 on all ports; dbg_ack=1 for the debug write.
5. Write r5=32'hA5A5A5A5 while rd_addr[0]=5 in the same cycle -> without REGFILE_BYPASS_EN, port 0 shows the old value (0) that cycle and A5A5A5A5 the next. With the macro defined, it shows A5A5A5A5 immediately.
6. Reassert rst at clear cycle 10, and attempt we=1 during CLEAR -> clear restarts at 1 and completes 31 cycles after the new release. The attempted write has no effect; the target register reads 0.

Source files
------------

// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp: parametrised multi-read-port MIPS register file with sequenced clear and debug write port; optional REGFILE_BYPASS_EN write-first forwarding
module mips_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     dbg_ack,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] clr_ptr, clr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic ready, wr_fn, wr_dbg;
  assign ready = !rst && state == READY;
  assign wr_fn = ready && we && wr_addr != '0;
  assign wr_dbg = ready && dbg_we && !we && dbg_addr != '0;
  // next state: walk the clear pointer up to the last register, then go ready
  always_comb begin
    state_d = (state == CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) ? READY : state;
    clr_d = state == CLEAR ? clr_ptr + 1'b1 : clr_ptr;
  end
  // state, clear pointer, busy and debug ack registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= ADDR_W'(1);
      busy <= 1'b1;
      dbg_ack <= 1'b0;
    end else begin
      state <= state_d;
      clr_ptr <= clr_d;
      busy <= state_d == CLEAR;
      dbg_ack <= state == READY && dbg_we && !we;
    end
  end
  // storage: clear sweep, then writeback port with priority over the debug port
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[clr_ptr] <= '0;
    if (wr_fn) mem[wr_addr] <= wr_data;
    if (wr_dbg) mem[dbg_addr] <= dbg_wdata;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[i*DATA_W +: DATA_W] = (busy || a == '0) ? '0 : (we && wr_addr == a) ? wr_data : mem[a];
`else
    assign rd_data[i*DATA_W +: DATA_W] = (busy || a == '0) ? '0 : mem[a];
`endif
  end
endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb_mips_regfile_mp: randomized self-checking bench against a behavioural register file model
module tb_mips_regfile_mp;
  localparam int NR = 2;
  logic clk = 0, rst = 1;
  logic [NR*5-1:0] rd_addr = '0;
  logic [NR*32-1:0] rd_data;
  logic we = 0, dbg_we = 0, dbg_ack, busy;
  logic [4:0] wr_addr = '0, dbg_addr = '0;
  logic [31:0] wr_data = '0, dbg_wdata = '0;
  int errs = 0, checks = 0;
  logic [31:0] m_mem [32];
  int m_left = 31;
  logic m_ack = 0;
  int n;

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (m_left > 0 || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  task automatic check_all();
    check("busy", {31'b0, busy}, {31'b0, m_left > 0});
    check("dbg_ack", {31'b0, dbg_ack}, {31'b0, m_ack});
    for (int i = 0; i < NR; i++)
      check($sformatf("rd%0d@%0d", i, rd_addr[i*5 +: 5]), rd_data[i*32 +: 32], model_read(rd_addr[i*5 +: 5]));
  endtask

  task automatic tick();
    if (rst) begin
      m_left = 31;
      m_ack = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int r = 0; r < 32; r++) m_mem[r] = 0;
      m_ack = 0;
    end else begin
      if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
      else if (dbg_we && !we && dbg_addr != 0) m_mem[dbg_addr] = dbg_wdata;
      m_ack = dbg_we && !we;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; dbg_we = 0;
  endtask

  task automatic settle_check();
    #1;
    check_all();
  endtask

  task automatic count_clear(input string tag);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      rd_addr = NR*5'($urandom);
      settle_check();
      tick();
      n++;
    end
    check(tag, n, 31);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_mem[r] = 32'hx;
    #1;
    tick(); tick();
    rst = 0;
    settle_check();
    count_clear("clear_len");
    for (int a = 0; a < 32; a += NR) begin
      for (int i = 0; i < NR; i++) rd_addr[i*5 +: 5] = 5'(a + i);
      #1;
      for (int i = 0; i < NR; i++) check($sformatf("zero_r%0d", a + i), rd_data[i*32 +: 32], 32'h0);
    end
    dbg_we = 1; dbg_addr = 1; dbg_wdata = 32'h1;
    tick();
    check("ack_r1", {31'b0, dbg_ack}, 32'h1);
    dbg_addr = 2; dbg_wdata = 32'h0;
    tick();
    check("ack_r2", {31'b0, dbg_ack}, 32'h1);
    idle();
    rd_addr = {5'd2, 5'd1};
    tick();
    check("ack_drop", {31'b0, dbg_ack}, 32'h0);
    check("rd_pre", rd_data, {32'h0, 32'h1});
    we = 1; wr_addr = 2; wr_data = 32'h1;
    dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'hDEADBEEF;
    tick();
    idle();
    rd_addr = {5'd3, 5'd2};
    #1;
    check("both_ack", {31'b0, dbg_ack}, 32'h0);
    check("both_rd", rd_data, {32'h0, 32'h1});
    we = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    tick();
    we = 0; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hFFFFFFFF;
    tick();
    idle();
    rd_addr = '0;
    #1;
    check("r0_ack", {31'b0, dbg_ack}, 32'h1);
    check("r0_rd", rd_data, 64'h0);
    we = 1; wr_addr = 5; wr_data = 32'hA5A5A5A5; rd_addr = {5'd1, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc", rd_data[31:0], 32'hA5A5A5A5);
`else
    check("same_cyc", rd_data[31:0], 32'h0);
`endif
    check("same_cyc_p1", rd_data[63:32], 32'h1);
    tick();
    idle();
    #1;
    check("next_cyc", rd_data[31:0], 32'hA5A5A5A5);
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    we = 1; wr_addr = 7; wr_data = 32'h12345678;
    count_clear("reclear_len");
    idle();
    rd_addr = {5'd5, 5'd7};
    #1;
    check("clr_wr_r7", rd_data[31:0], 32'h0);
    check("clr_r5", rd_data[63:32], 32'h0);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      we = $urandom_range(0, 2) == 0;
      wr_addr = 5'($urandom_range(0, 7));
      wr_data = $urandom;
      dbg_we = $urandom_range(0, 2) == 0;
      dbg_addr = 5'($urandom_range(0, 7));
      dbg_wdata = $urandom;
      rd_addr = NR*5'($urandom);
      if ($urandom_range(0, 1) == 0) rd_addr[4:0] = wr_addr;
      settle_check();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
